// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps a 4:1 mux select through channels 0..3.
// On each channel it waits SETTLE_CYCLES, then captures mux_out. After
// channel 3 it presents all four bits as one word with a one-cycle valid.
// Optional feature macro: MUX_SCAN_CHANGE_DET_EN adds a registered
// 'changed' flag comparing each completed sample with the previous one.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; sel holds last channel
// SETTLE  | sel driven, counting settle cycles
// CAPTURE | sample mux_out at the closing edge, advance or finish
// DONE    | sample word valid for exactly one cycle
module mux_scan_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mux_out,
  output logic [1:0] sel,
  output logic [3:0] sample,
  output logic       valid,
`ifdef MUX_SCAN_CHANGE_DET_EN
  output logic       changed,
`endif
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [1:0] sel_nxt;
  logic [2:0] shadow, shadow_nxt;
  logic [3:0] sample_nxt;
  logic       valid_nxt, busy_nxt;

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      sel    <= '0;
      shadow <= '0;
      sample <= '0;
      valid  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      sel    <= sel_nxt;
      shadow <= shadow_nxt;
      sample <= sample_nxt;
      valid  <= valid_nxt;
      busy   <= busy_nxt;
    end
  end

  // Next-state and next-output decode; valid/busy follow the next state so
  // that they are registered alongside it.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    sel_nxt    = sel;
    shadow_nxt = shadow;
    sample_nxt = sample;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SETTLE;
          sel_nxt   = 2'd0;
          cnt_nxt   = 4'd0;
        end
      end
      SETTLE: begin
        if (cnt == SETTLE_LAST) state_nxt = CAPTURE;
        else                    cnt_nxt   = cnt + 4'd1;
      end
      CAPTURE: begin
        if (sel != 2'd3) begin
          case (sel)
            2'd0:    shadow_nxt[0] = mux_out;
            2'd1:    shadow_nxt[1] = mux_out;
            default: shadow_nxt[2] = mux_out;
          endcase
          sel_nxt   = sel + 2'd1;
          cnt_nxt   = 4'd0;
          state_nxt = SETTLE;
        end else begin
          // Whole word lands on one edge so sample is never partial.
          sample_nxt = {mux_out, shadow};
          state_nxt  = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt  = (state_nxt == SETTLE) || (state_nxt == CAPTURE);
    valid_nxt = (state_nxt == DONE);
  end

`ifdef MUX_SCAN_CHANGE_DET_EN
  logic [3:0] prev, prev_nxt;
  logic       changed_nxt;

  // Compare the word being committed against the previously committed one.
  always_comb begin
    prev_nxt    = prev;
    changed_nxt = changed;
    if ((state == CAPTURE) && (sel == 2'd3)) begin
      changed_nxt = (sample_nxt != prev);
      prev_nxt    = sample_nxt;
    end
  end

  // Previous-sample and change-flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev    <= '0;
      changed <= 1'b0;
    end else begin
      prev    <= prev_nxt;
      changed <= changed_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: two instances (settle 1 and settle 3),
// each fed by a modelled 4:1 mux, checked every cycle against a
// scan-timeline model plus directed literal expectations.
module tb_mux_scan_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_s  [2];
  logic [3:0] in_v     [2];
  logic       mux_s    [2];
  logic [1:0] sel_s    [2];
  logic [3:0] sample_s [2];
  logic       valid_s  [2];
  logic       busy_s   [2];
`ifdef MUX_SCAN_CHANGE_DET_EN
  logic       changed_s[2];
`endif

  int total = 0;
  int bad   = 0;

  assign mux_s[0] = in_v[0][sel_s[0]];
  assign mux_s[1] = in_v[1][sel_s[1]];

  mux_scan_sequencer #(.SETTLE_CYCLES(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .mux_out(mux_s[0]),
    .sel(sel_s[0]), .sample(sample_s[0]), .valid(valid_s[0]),
`ifdef MUX_SCAN_CHANGE_DET_EN
    .changed(changed_s[0]),
`endif
    .busy(busy_s[0])
  );

  mux_scan_sequencer #(.SETTLE_CYCLES(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .mux_out(mux_s[1]),
    .sel(sel_s[1]), .sample(sample_s[1]), .valid(valid_s[1]),
`ifdef MUX_SCAN_CHANGE_DET_EN
    .changed(changed_s[1]),
`endif
    .busy(busy_s[1])
  );

  task automatic chk(input string name, input int d, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t got=%0d want=%0d", name, d, $time, act, exp);
    end
  endtask

  // Timeline model: k = cycle index within a scan (0 = not scanning).
  // Cycles 1..4L are busy with channel (k-1)/L, channel c is captured at
  // the edge ending cycle (c+1)L, cycle 4L+1 is the valid cycle.
  function automatic int len(input int d);
    return (d == 0) ? 2 : 4;
  endfunction

  int         k_m      [2] = '{0, 0};
  logic [3:0] cap_m    [2] = '{4'h0, 4'h0};
  logic [3:0] sample_m [2] = '{4'h0, 4'h0};
  logic [3:0] prev_m   [2] = '{4'h0, 4'h0};
  logic [1:0] sel_m    [2] = '{2'd0, 2'd0};
  logic       changed_m[2] = '{1'b0, 1'b0};
  int         ml, mn;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        k_m[d] = 0; cap_m[d] = 4'h0; sample_m[d] = 4'h0;
        prev_m[d] = 4'h0; sel_m[d] = 2'd0; changed_m[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        ml = len(d);
        mn = 4 * ml;
        if (k_m[d] == 0) begin
          if (start_s[d]) k_m[d] = 1;
        end else if (k_m[d] <= mn) begin
          if (k_m[d] % ml == 0) cap_m[d][k_m[d]/ml-1] = in_v[d][k_m[d]/ml-1];
          if (k_m[d] == mn) begin
            sample_m[d]  = cap_m[d];
            changed_m[d] = (cap_m[d] != prev_m[d]);
            prev_m[d]    = cap_m[d];
          end
          k_m[d] = k_m[d] + 1;
        end else begin
          k_m[d] = 0;
        end
        if (k_m[d] >= 1 && k_m[d] <= mn) sel_m[d] = 2'((k_m[d] - 1) / ml);
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk("sel", d, int'(sel_s[d]), int'(sel_m[d]));
      chk("sample", d, int'(sample_s[d]), int'(sample_m[d]));
      chk("valid", d, int'(valid_s[d]), int'(k_m[d] == 4 * len(d) + 1));
      chk("busy", d, int'(busy_s[d]), int'(k_m[d] >= 1 && k_m[d] <= 4 * len(d)));
`ifdef MUX_SCAN_CHANGE_DET_EN
      chk("changed", d, int'(changed_s[d]), int'(changed_m[d]));
`endif
    end
  end

  // Counts negedges until valid is seen; -1 if the budget expires.
  task automatic wait_valid(input int d, output int cyc);
    cyc = -1;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (valid_s[d]) begin
        cyc = i;
        break;
      end
    end
  endtask

  // Called at posedge+2; start is sampled at the next edge (edge 0).
  task automatic run_scan(input int d, input logic [3:0] v, output int cyc);
    in_v[d]    = v;
    start_s[d] = 1'b1;
    @(posedge clk); #2;
    start_s[d] = 1'b0;
    wait_valid(d, cyc);
  endtask

  task automatic to_next_cycle();
    @(posedge clk); #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int c, nv;
    rst_n = 1'b1;
    start_s[0] = 1'b0; start_s[1] = 1'b0;
    in_v[0] = 4'h0;    in_v[1] = 4'h0;
    #1 rst_n = 1'b0;
    #2;
    for (int d = 0; d < 2; d++) begin
      chk("rst_sel", d, int'(sel_s[d]), 0);
      chk("rst_sample", d, int'(sample_s[d]), 0);
      chk("rst_valid", d, int'(valid_s[d]), 0);
      chk("rst_busy", d, int'(busy_s[d]), 0);
`ifdef MUX_SCAN_CHANGE_DET_EN
      chk("rst_changed", d, int'(changed_s[d]), 0);
`endif
    end
    to_next_cycle();
    rst_n = 1'b1;
    repeat (2) to_next_cycle();

    // Single scan of 4'hA: valid in cycle 9.
    run_scan(0, 4'hA, c);
    chk("lat_s1", 0, c, 9);
    chk("samp_a", 0, int'(sample_s[0]), 'hA);
    to_next_cycle();

    // Held start: back-to-back scans every 10 cycles.
    in_v[0] = 4'h6;
    start_s[0] = 1'b1;
    wait_valid(0, c);
    chk("samp_6", 0, int'(sample_s[0]), 'h6);
    for (int i = 0; i < 2; i++) begin
      wait_valid(0, c);
      chk("period", 0, c, 10);
      chk("samp_6", 0, int'(sample_s[0]), 'h6);
    end
    start_s[0] = 1'b0;
    repeat (2) to_next_cycle();

    // Input switched 0 -> F after the channel-1 capture edge.
    in_v[0] = 4'h0;
    start_s[0] = 1'b1;
    to_next_cycle();
    start_s[0] = 1'b0;
    repeat (4) to_next_cycle();
    in_v[0] = 4'hF;
    wait_valid(0, c);
    chk("lat_sw1", 0, (c < 0) ? -1 : c + 4, 9);
    chk("samp_c", 0, int'(sample_s[0]), 'hC);
    to_next_cycle();

    // Same with settle 3: channel-1 capture edge is edge 8, valid cycle 17.
    in_v[1] = 4'h0;
    start_s[1] = 1'b1;
    to_next_cycle();
    start_s[1] = 1'b0;
    repeat (8) to_next_cycle();
    in_v[1] = 4'hF;
    wait_valid(1, c);
    chk("lat_sw3", 1, (c < 0) ? -1 : c + 8, 17);
    chk("samp_c", 1, int'(sample_s[1]), 'hC);
    to_next_cycle();

    // Reset pulse in cycle 5 of a scan.
    in_v[0] = 4'h3;
    start_s[0] = 1'b1;
    to_next_cycle();
    start_s[0] = 1'b0;
    repeat (4) to_next_cycle();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sel", 0, int'(sel_s[0]), 0);
    chk("mid_rst_sample", 0, int'(sample_s[0]), 0);
    chk("mid_rst_busy", 0, int'(busy_s[0]), 0);
    chk("mid_rst_valid", 0, int'(valid_s[0]), 0);
    to_next_cycle();
    rst_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid_s[0]) nv++;
    end
    chk("no_valid_after_rst", 0, nv, 0);
    to_next_cycle();
    run_scan(0, 4'h9, c);
    chk("lat_after_rst", 0, c, 9);
    chk("samp_9", 0, int'(sample_s[0]), 'h9);
    to_next_cycle();

`ifdef MUX_SCAN_CHANGE_DET_EN
    run_scan(0, 4'hA, c);
    chk("chg_first_a", 0, int'(changed_s[0]), 1);
    to_next_cycle();
    run_scan(0, 4'hA, c);
    chk("chg_second_a", 0, int'(changed_s[0]), 0);
    to_next_cycle();
    run_scan(0, 4'h5, c);
    chk("chg_5", 0, int'(changed_s[0]), 1);
    to_next_cycle();
`endif

    repeat (3) to_next_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_scan_sequencer.md
# mux_scan_sequencer

Sequential channel scanner that drives the 2-bit select of the team's 4:1 multiplexer and samples its 1-bit output. On a start request it steps through channels 0–3, waits a programmable settle time on each, captures the mux output bit by bit, then presents all four bits as one atomic 4-bit word with a one-cycle valid strobe. It sits directly upstream of the mux on `sel` and directly downstream of it on `out`, turning the combinational selector into a periodic 4-bit sampler.

## Interface
- `SETTLE_CYCLES`, 1: cycles `sel` is held stable before sampling; legal range 1..15.
- `clk`  input  1  clock; all state changes on rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `start`  input  1  scan request; sampled only in IDLE.
- `mux_out`  input  1  output of the 4:1 mux (`out`), equal to `in[sel]`.
- `sel`  output  2  channel select to the mux.
- `sample`  output  4  last completed scan; bit n = mux output with `sel`=n.
- `valid`  output  1  one-cycle strobe; `sample` is new.
- `busy`  output  1  high while a scan is in progress (SETTLE/CAPTURE).
- `changed`  output  1  present only with `MUX_SCAN_CHANGE_DET_EN` (see Configuration).

## Operation
- Reset values: state IDLE, `sel`=0, `sample`=0, `valid`=0, `busy`=0, settle counter=0, shadow=0, `changed`=0.
- States: IDLE, SETTLE, CAPTURE, DONE; `busy`=1 in SETTLE/CAPTURE, `valid`=1 only in DONE.
- IDLE: `start`=1 at an edge → SETTLE, `sel`<=0, counter<=0. `start`=0 → stay.
- SETTLE: counter==SETTLE_CYCLES-1 → CAPTURE; else counter+1.
- CAPTURE, `sel`<3: shadow[`sel`]<=`mux_out`, `sel`<=`sel`+1, counter<=0 → SETTLE.
- CAPTURE, `sel`==3: `sample`<={`mux_out`, shadow[2:0]} in one edge → DONE. `sel` stays 3.
- DONE: one cycle → IDLE unconditionally.
- `start` outside IDLE ignored; no queuing. Held `start` yields back-to-back scans.
- `sample` changes only on the final capture edge; never partially updated.
- `sel` wraps only by the reset-to-0 on scan start; it never increments past 3.

## Timing
- Per channel: SETTLE_CYCLES + 1 cycles. `mux_out` sampled at the end of CAPTURE, after `sel` stable SETTLE_CYCLES+1 cycles.
- Start accepted at edge 0 → `valid` high during cycle 4·(SETTLE_CYCLES+1)+1 (9 for default).
- `start` held high: scan period 4·(SETTLE_CYCLES+1)+2 cycles (DONE and IDLE each take one).
- `rst_n` low mid-scan: all outputs to reset values immediately, no `valid`, scan lost. First edge with `rst_n` high behaves as IDLE.
- All outputs registered; no combinational path input → output.

## Configuration
- `MUX_SCAN_CHANGE_DET_EN` defined: a 4-bit previous-sample register (reset 0) is added. `changed` is registered and loaded on the final capture edge with (new `sample` != previous `sample`). It is therefore valid alongside `valid` and holds until the next scan completes. The previous register then updates to the new sample.
- Not defined: no `changed` port, no previous-sample register; behaviour otherwise identical.

## Test plan
Mux model: `mux_out` = `in[sel]`; SETTLE_CYCLES=1 unless stated.
- Reset: assert `rst_n`=0 → `sel`=0, `sample`=0, `valid`=0, `busy`=0 (`changed`=0) with no clock edge required.
- `in`=4'hA, one-cycle `start` → `sel` sequence 0,0,1,1,2,2,3,3 over cycles 1–8; `busy`=1 in cycles 1–8; `valid`=1 only in cycle 9; `sample`=4'hA.
- `start` held high, `in`=4'h6 → `valid` pulses every 10 cycles, each with `sample`=4'h6. `start` during a scan is ignored, with no extra scan.
- `in`=4'h0, switched to 4'hF after the channel-1 capture edge → `sample`=4'hC. Repeat with SETTLE_CYCLES=3 → `valid` in cycle 17.
- `rst_n` pulsed low in cycle 5 of a scan → outputs 0 immediately, no `valid`. Next `start` with `in`=4'h9 → `sample`=4'h9.
- With `MUX_SCAN_CHANGE_DET_EN`, scans of `in`=4'hA, 4'hA, 4'h5 → `changed`=1, 0, 1 at the respective `valid` cycles.
